instr_sequencer: RTL and testbench

//  Control-unit FSM that drives the instruction-fetch memory: PC, instruction ROM and MIR.

---
 rtl/instr_sequencer.sv | 150 +++++++++++++++
 tb/tb_instr_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM driving PC, ROM, MIR and datapath strobes
// Outputs are decoded from the state and the MIR fields, so reset clears them asynchronously.
module instr_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int IMM_W        = 7,
  parameter int RESET_VECTOR = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [3:0]        OPCODE,
  input  logic              I_Flag,
  input  logic [IMM_W-1:0]  ImediateADDR,
  input  logic              ZERO,
  input  logic              CARRY,
  output logic              ROM_CS,
  output logic              ROM_OE,
  output logic              IR_EN,
  output logic              PC_EN,
  output logic              LOAD_EN,
  output logic [ADDR_W-1:0] InstADDR,
  output logic [IMM_W-1:0]  RAM_ADDR,
  output logic              RAM_CS,
  output logic              RAM_OE,
  output logic              RAM_WS,
  output logic [3:0]        ALU_OP,
  output logic              SRC_IMM,
  output logic              ACC_EN,
  output logic              FLAG_EN,
  output logic              ILLEGAL,
  output logic              HALTED
);

  typedef enum logic [2:0] {
    S_RST, S_BOOT, S_FETCH, S_LATCH, S_DECODE, S_EXEC1, S_EXEC2, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state;
  logic   is_alu;
  logic   is_sta;
  logic   is_lda;
  logic   is_reserved;
  logic   branch_taken;

  assign is_alu       = (OPCODE == OP_LDA) || (OPCODE inside {[4'h3:4'h8]});
  assign is_sta       = (OPCODE == OP_STA);
  assign is_lda       = (OPCODE == OP_LDA);
  assign is_reserved  = (OPCODE inside {[4'hC:4'hE]});
  assign branch_taken = (OPCODE == OP_JMP) || ((OPCODE == OP_JZ) && ZERO) ||
                        ((OPCODE == OP_JC) && CARRY);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:    state <= S_BOOT;
        S_BOOT:   state <= S_FETCH;
        S_FETCH:  state <= S_LATCH;
        S_LATCH:  state <= S_DECODE;
        S_DECODE: begin
          if (OPCODE == OP_HLT)        state <= S_HALT;
          else if (is_alu || is_sta)   state <= S_EXEC1;
          else                         state <= S_FETCH;
        end
        // Only memory-sourced ALU/LDA ops need the second RAM read cycle.
        S_EXEC1:  state <= (is_alu && !I_Flag) ? S_EXEC2 : S_FETCH;
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_RST;
      endcase
    end
  end

  always_comb begin
    ROM_CS   = 1'b0;
    ROM_OE   = 1'b0;
    IR_EN    = 1'b0;
    PC_EN    = 1'b0;
    LOAD_EN  = 1'b0;
    InstADDR = '0;
    RAM_ADDR = '0;
    RAM_CS   = 1'b0;
    RAM_OE   = 1'b0;
    RAM_WS   = 1'b0;
    ALU_OP   = 4'h0;
    SRC_IMM  = 1'b0;
    ACC_EN   = 1'b0;
    FLAG_EN  = 1'b0;
    ILLEGAL  = 1'b0;
    HALTED   = 1'b0;
    case (state)
      S_BOOT: begin
        PC_EN    = 1'b1;
        LOAD_EN  = 1'b1;
        InstADDR = ADDR_W'(RESET_VECTOR);
      end
      S_FETCH: begin
        ROM_CS = 1'b1;
        ROM_OE = 1'b1;
      end
      S_LATCH: begin
        ROM_CS = 1'b1;
        ROM_OE = 1'b1;
        IR_EN  = 1'b1;
      end
      S_DECODE: begin
        PC_EN   = (OPCODE != OP_HLT);
        ILLEGAL = is_reserved;
        if (branch_taken) begin
          LOAD_EN  = 1'b1;
          InstADDR = ImediateADDR[ADDR_W-1:0];
        end
      end
      S_EXEC1: begin
        ALU_OP = OPCODE;
        if (is_sta) begin
          RAM_CS   = 1'b1;
          RAM_WS   = 1'b1;
          RAM_ADDR = ImediateADDR;
        end else if (is_alu && I_Flag) begin
          SRC_IMM = 1'b1;
          ACC_EN  = 1'b1;
          FLAG_EN = !is_lda;
        end else if (is_alu) begin
          RAM_CS   = 1'b1;
          RAM_OE   = 1'b1;
          RAM_ADDR = ImediateADDR;
        end
      end
      S_EXEC2: begin
        ALU_OP   = OPCODE;
        RAM_CS   = 1'b1;
        RAM_OE   = 1'b1;
        RAM_ADDR = ImediateADDR;
        ACC_EN   = 1'b1;
        FLAG_EN  = !is_lda;
      end
      S_HALT: HALTED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench for instr_sequencer with RESET_VECTOR=5
module tb_instr_sequencer;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 7;

  localparam logic [12:0] ROMCS   = 13'h1000;
  localparam logic [12:0] ROMOE   = 13'h0800;
  localparam logic [12:0] IREN    = 13'h0400;
  localparam logic [12:0] PCEN    = 13'h0200;
  localparam logic [12:0] LOADEN  = 13'h0100;
  localparam logic [12:0] RAMCS   = 13'h0080;
  localparam logic [12:0] RAMOE   = 13'h0040;
  localparam logic [12:0] RAMWS   = 13'h0020;
  localparam logic [12:0] SRCIMM  = 13'h0010;
  localparam logic [12:0] ACCEN   = 13'h0008;
  localparam logic [12:0] FLAGEN  = 13'h0004;
  localparam logic [12:0] ILL     = 13'h0002;
  localparam logic [12:0] HLTD    = 13'h0001;
  localparam logic [12:0] NONE    = 13'h0000;

  logic              CLK;
  logic              RST_N;
  logic [3:0]        OPCODE;
  logic              I_Flag;
  logic [IMM_W-1:0]  ImediateADDR;
  logic              ZERO;
  logic              CARRY;
  logic              ROM_CS, ROM_OE, IR_EN, PC_EN, LOAD_EN;
  logic [ADDR_W-1:0] InstADDR;
  logic [IMM_W-1:0]  RAM_ADDR;
  logic              RAM_CS, RAM_OE, RAM_WS;
  logic [3:0]        ALU_OP;
  logic              SRC_IMM, ACC_EN, FLAG_EN, ILLEGAL, HALTED;

  int total = 0;
  int bad   = 0;

  instr_sequencer #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .RESET_VECTOR(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .I_Flag(I_Flag),
    .ImediateADDR(ImediateADDR), .ZERO(ZERO), .CARRY(CARRY),
    .ROM_CS(ROM_CS), .ROM_OE(ROM_OE), .IR_EN(IR_EN), .PC_EN(PC_EN),
    .LOAD_EN(LOAD_EN), .InstADDR(InstADDR), .RAM_ADDR(RAM_ADDR),
    .RAM_CS(RAM_CS), .RAM_OE(RAM_OE), .RAM_WS(RAM_WS), .ALU_OP(ALU_OP),
    .SRC_IMM(SRC_IMM), .ACC_EN(ACC_EN), .FLAG_EN(FLAG_EN),
    .ILLEGAL(ILLEGAL), .HALTED(HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic mir(input logic [3:0] op, input logic imm_flag, input logic [6:0] addr);
    OPCODE       = op;
    I_Flag       = imm_flag;
    ImediateADDR = addr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] s, input logic [4:0] ia,
                     input logic [6:0] ra, input logic [3:0] op);
    logic [28:0] obs;
    logic [28:0] exp;
    obs = {ROM_CS, ROM_OE, IR_EN, PC_EN, LOAD_EN, RAM_CS, RAM_OE, RAM_WS,
           SRC_IMM, ACC_EN, FLAG_EN, ILLEGAL, HALTED, InstADDR, RAM_ADDR, ALU_OP};
    exp = {s, ia, ra, op};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    OPCODE = 4'h3; I_Flag = 1'b0; ImediateADDR = 7'h45; ZERO = 1'b1; CARRY = 1'b1;
    tick(); tick();
    chk("reset", NONE, 5'h00, 7'h00, 4'h0);
    RST_N = 1'b1; #1;
    chk("rst_hold", NONE, 5'h00, 7'h00, 4'h0);
    tick(); chk("boot", PCEN | LOADEN, 5'h05, 7'h00, 4'h0);
    tick(); chk("fetch0", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);
    tick(); chk("latch0", ROMCS | ROMOE | IREN, 5'h00, 7'h00, 4'h0);

    ZERO = 1'b0; CARRY = 1'b0;
    mir(4'h3, 1'b1, 7'h12);
    tick(); chk("add_imm_decode", PCEN, 5'h00, 7'h00, 4'h0);
    tick(); chk("add_imm_exec1", SRCIMM | ACCEN | FLAGEN, 5'h00, 7'h00, 4'h3);
    tick(); chk("add_imm_next_fetch", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);

    tick(); mir(4'h1, 1'b0, 7'h45);
    tick(); chk("lda_decode", PCEN, 5'h00, 7'h00, 4'h0);
    tick(); chk("lda_exec1", RAMCS | RAMOE, 5'h00, 7'h45, 4'h1);
    tick(); chk("lda_exec2", RAMCS | RAMOE | ACCEN, 5'h00, 7'h45, 4'h1);
    tick(); chk("lda_next_fetch", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);

    tick(); ZERO = 1'b1; mir(4'hA, 1'b0, 7'h7F);
    tick(); chk("jz_taken", PCEN | LOADEN, 5'h1F, 7'h00, 4'h0);
    tick(); chk("jz_next_fetch", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);
    tick(); ZERO = 1'b0; mir(4'hA, 1'b0, 7'h7F);
    tick(); chk("jz_not_taken", PCEN, 5'h00, 7'h00, 4'h0);
    tick(); tick(); CARRY = 1'b1; mir(4'hB, 1'b0, 7'h2A);
    tick(); chk("jc_taken", PCEN | LOADEN, 5'h0A, 7'h00, 4'h0);
    tick(); tick(); CARRY = 1'b0; mir(4'h9, 1'b0, 7'h23);
    tick(); chk("jmp", PCEN | LOADEN, 5'h03, 7'h00, 4'h0);

    tick(); tick(); mir(4'h2, 1'b1, 7'h3C);
    tick(); chk("sta_decode", PCEN, 5'h00, 7'h00, 4'h0);
    tick(); chk("sta_exec1", RAMCS | RAMWS, 5'h00, 7'h3C, 4'h2);
    tick(); chk("sta_next_fetch", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);

    tick(); mir(4'hD, 1'b0, 7'h10);
    tick(); chk("illegal_decode", PCEN | ILL, 5'h00, 7'h00, 4'h0);
    tick(); chk("illegal_next_fetch", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);

    tick(); mir(4'hF, 1'b0, 7'h55);
    tick(); chk("hlt_decode", NONE, 5'h00, 7'h00, 4'h0);
    tick(); chk("halt", HLTD, 5'h00, 7'h00, 4'h0);
    ZERO = 1'b1; mir(4'h3, 1'b0, 7'h22);
    repeat (4) tick();
    chk("halt_stuck", HLTD, 5'h00, 7'h00, 4'h0);
    RST_N = 1'b0; #1;
    chk("halt_async_reset", NONE, 5'h00, 7'h00, 4'h0);
    tick(); RST_N = 1'b1;
    tick(); chk("boot_after_halt", PCEN | LOADEN, 5'h05, 7'h00, 4'h0);

    ZERO = 1'b0;
    tick(); tick(); mir(4'h3, 1'b0, 7'h11);
    tick(); chk("add_mem_decode", PCEN, 5'h00, 7'h00, 4'h0);
    tick(); chk("add_mem_exec1", RAMCS | RAMOE, 5'h00, 7'h11, 4'h3);
    tick(); chk("add_mem_exec2", RAMCS | RAMOE | ACCEN | FLAGEN, 5'h00, 7'h11, 4'h3);
    RST_N = 1'b0; #1;
    chk("exec2_async_reset", NONE, 5'h00, 7'h00, 4'h0);
    tick(); chk("exec2_reset_hold", NONE, 5'h00, 7'h00, 4'h0);
    RST_N = 1'b1;
    tick(); chk("boot_after_abort", PCEN | LOADEN, 5'h05, 7'h00, 4'h0);
    tick(); chk("fetch_after_abort", ROMCS | ROMOE, 5'h00, 7'h00, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
